// File: rtl/sort3_stream_if.sv
// +----------------------------------------------------------------------+
// | sort3_stream_if : handshake bundle for the 3-word streaming sorter    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface sort3_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_desc;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    // slave is the sorter side, master is the producer/consumer side
    modport slave (
        input  in_valid, in_data, in_desc, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_desc, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/sort3_stream.sv
// +----------------------------------------------------------------------+
// | sort3_stream : serial 3-value sorter, load / 3x compare-swap / emit   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sort3_stream #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sort3_stream_if.slave  bus
);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_CMP0 = 3'd1;
    localparam logic [2:0] S_CMP1 = 3'd2;
    localparam logic [2:0] S_CMP2 = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            ecnt_q, ecnt_d;
    logic                  dir_q, dir_d;
    logic                  out_valid_q, out_valid_d;
    logic [2:0][WIDTH-1:0] val_q, val_d;
    logic [2:0][1:0]       idx_q, idx_d;

    logic [1:0]            lpos_w, rpos_w;
    logic [WIDTH-1:0]      lval_w, rval_w;
    logic                  swap_w;

    // CMP1 works on slots 1/2; CMP0 and CMP2 both work on slots 0/1
    always_comb begin
        lpos_w = (state_q == S_CMP1) ? 2'd1 : 2'd0;
        rpos_w = lpos_w + 2'd1;
        lval_w = val_q[lpos_w];
        rval_w = val_q[rpos_w];
        swap_w = dir_q ? (lval_w < rval_w) : (lval_w > rval_w);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ecnt_d      = ecnt_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        val_d       = val_q;
        idx_d       = idx_q;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    val_d[cnt_q] = bus.in_data;
                    idx_d[cnt_q] = cnt_q;
                    if (cnt_q == 2'd0) begin
                        dir_d = bus.in_desc;
                    end
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = S_CMP0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_CMP0, S_CMP1, S_CMP2: begin
                if (swap_w) begin
                    val_d[lpos_w] = rval_w;
                    val_d[rpos_w] = lval_w;
                    idx_d[lpos_w] = idx_q[rpos_w];
                    idx_d[rpos_w] = idx_q[lpos_w];
                end
                if (state_q == S_CMP0) begin
                    state_d = S_CMP1;
                end else if (state_q == S_CMP1) begin
                    state_d = S_CMP2;
                end else begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    ecnt_d      = 2'd0;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (ecnt_q == 2'd2) begin
                        out_valid_d = 1'b0;
                        ecnt_d      = 2'd0;
                        state_d     = S_LOAD;
                    end else begin
                        ecnt_d = ecnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= 2'd0;
            ecnt_q      <= 2'd0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            val_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ecnt_q      <= ecnt_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            val_q       <= val_d;
            idx_q       <= idx_d;
        end
    end

    // Slots are frozen during EMIT, so the output mux is stable under backpressure
    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? val_q[ecnt_q] : '0;
    assign bus.out_idx   = out_valid_q ? idx_q[ecnt_q] : 2'd0;
    assign bus.out_last  = out_valid_q && (ecnt_q == 2'd2);
    assign bus.busy      = !((state_q == S_LOAD) && (cnt_q == 2'd0));

endmodule

`default_nettype wire

// File: tb/tb_sort3_stream.sv
// +----------------------------------------------------------------------+
// | tb_sort3_stream : directed stimulus with queue-based output checker   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sort3_stream;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    sort3_stream_if #(.WIDTH(8)) ifc ();

    sort3_stream #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] i, input logic l);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push3(input logic [7:0] d0, input logic [1:0] i0,
                         input logic [7:0] d1, input logic [1:0] i1,
                         input logic [7:0] d2, input logic [1:0] i2);
        push(d0, i0, 1'b0);
        push(d1, i1, 1'b0);
        push(d2, i2, 1'b1);
    endtask

    // Monitor: pop and compare on every output transfer
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data=%0h idx=%0d, expected none", ifc.out_data, ifc.out_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(ifc.out_data), 32'(e.data));
                chk("out_idx",  32'(ifc.out_idx),  32'(e.idx));
                chk("out_last", 32'(ifc.out_last), 32'(e.last));
            end
        end
    end

    // All tasks below start and end at 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic desc, input int gap);
        int n;
        n = 0;
        while (!ifc.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!ifc.in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_desc  = desc;
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        for (int g = 0; g < gap; g++) begin
            chk("busy_gap", 32'(ifc.busy), 32'd1);
            chk("in_ready_gap", 32'(ifc.in_ready), 32'd1);
            tick();
        end
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!ifc.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("out_valid_wait", 32'(ifc.out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !ifc.in_ready || ifc.out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_in_ready", 32'(ifc.in_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        chk("rst_busy",      32'(ifc.busy),      32'd0);
    endtask

    initial begin
        logic [7:0] hd;
        logic [1:0] hi;
        logic       hl;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'h00;
        ifc.in_desc   = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_in_ready",  32'(ifc.in_ready),  32'd1);
        chk("reset_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset_out_data",  32'(ifc.out_data),  32'd0);
        chk("reset_out_idx",   32'(ifc.out_idx),   32'd0);
        chk("reset_out_last",  32'(ifc.out_last),  32'd0);
        chk("reset_busy",      32'(ifc.busy),      32'd0);

        // Ascending with latency check
        push3(8'h10, 2'd1, 8'h20, 2'd2, 8'h30, 2'd0);
        send(8'h30, 1'b0, 0);
        chk("busy_loading", 32'(ifc.busy), 32'd1);
        send(8'h10, 1'b0, 0);
        send(8'h20, 1'b0, 0);
        chk("lat_t1_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("lat_t1_in_ready",  32'(ifc.in_ready),  32'd0);
        tick();
        chk("lat_t2_out_valid", 32'(ifc.out_valid), 32'd0);
        tick();
        chk("lat_t3_out_valid", 32'(ifc.out_valid), 32'd0);
        tick();
        chk("lat_t3p_out_valid", 32'(ifc.out_valid), 32'd1);
        drain();

        // Descending
        push3(8'hFF, 2'd1, 8'h80, 2'd2, 8'h05, 2'd0);
        send(8'h05, 1'b1, 0);
        send(8'hFF, 1'b0, 0);
        send(8'h80, 1'b0, 0);
        drain();

        // Stability
        push3(8'h01, 2'd2, 8'h42, 2'd0, 8'h42, 2'd1);
        send(8'h42, 1'b0, 0);
        send(8'h42, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        drain();
        push3(8'h07, 2'd0, 8'h07, 2'd1, 8'h07, 2'd2);
        send(8'h07, 1'b0, 0);
        send(8'h07, 1'b0, 0);
        send(8'h07, 1'b0, 0);
        drain();

        // Backpressure on the first emitted word
        ifc.out_ready = 1'b0;
        push3(8'h11, 2'd2, 8'h22, 2'd0, 8'h99, 2'd1);
        send(8'h22, 1'b0, 0);
        send(8'h99, 1'b0, 0);
        send(8'h11, 1'b0, 0);
        wait_out_valid();
        hd = ifc.out_data;
        hi = ifc.out_idx;
        hl = ifc.out_last;
        chk("bp_first_data", 32'(hd), 32'h11);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_data_hold", 32'(ifc.out_data),  32'(hd));
            chk("bp_idx_hold",  32'(ifc.out_idx),   32'(hi));
            chk("bp_last_hold", 32'(ifc.out_last),  32'(hl));
            chk("bp_in_ready",  32'(ifc.in_ready),  32'd0);
            chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        ifc.out_ready = 1'b1;
        drain();

        // Input gaps, in_desc toggled on word 2 must be ignored
        push3(8'h0A, 2'd1, 8'h0B, 2'd2, 8'h0C, 2'd0);
        send(8'h0C, 1'b0, 3);
        send(8'h0A, 1'b1, 3);
        send(8'h0B, 1'b1, 0);
        drain();

        // Reset during CMP1: nothing from that batch may appear
        send(8'h50, 1'b0, 0);
        send(8'h40, 1'b0, 0);
        send(8'h60, 1'b0, 0);
        tick();
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            chk("post_rst1_no_out", 32'(ifc.out_valid), 32'd0);
            tick();
        end
        push3(8'h01, 2'd1, 8'h02, 2'd2, 8'h03, 2'd0);
        send(8'h03, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        drain();

        // Reset after the first emitted word
        ifc.out_ready = 1'b0;
        push(8'h04, 2'd1, 1'b0);
        send(8'h09, 1'b0, 0);
        send(8'h04, 1'b0, 0);
        send(8'h06, 1'b0, 0);
        wait_out_valid();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("mid_emit_second_data", 32'(ifc.out_data), 32'h06);
        pulse_reset();
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("post_rst2_no_out", 32'(ifc.out_valid), 32'd0);
            tick();
        end
        chk("post_rst2_queue", 32'(exp_q.size()), 32'd0);
        push3(8'h01, 2'd1, 8'h02, 2'd2, 8'h03, 2'd0);
        send(8'h03, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        drain();

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
